// File: rtl/hdc_pkg.sv
// Shared HDC definitions: hypervector types, bundler FSM states and the rotate helper.
package hdc_pkg;

    localparam int unsigned D  = 64;
    localparam int unsigned CH = 4;
    localparam int unsigned SW = $clog2(CH + 1);

    typedef logic [D-1:0] hv_t;
    typedef hv_t [CH-1:0] chan_hv_t;

    typedef enum logic [1:0] {
        StAccum  = 2'd0,
        StThresh = 2'd1,
        StEmit   = 2'd2
    } bund_state_e;

    function automatic hv_t rotl(input hv_t x, input int unsigned sh);
        int unsigned s;
        s = sh % D;
        if (s == 0) begin
            return x;
        end
        return (x << s) | (x >> (D - s));
    endfunction

endpackage

// File: rtl/hv_spatial_bind.sv
// Binds each channel HV to its channel identity by rotation and counts set bits per position.
module hv_spatial_bind
    import hdc_pkg::*;
#(
    parameter int unsigned ROT_STEP = 7
) (
    input  chan_hv_t                i_hv,
    output logic [D-1:0][SW-1:0]    o_sum
);

    chan_hv_t w_bound;

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            w_bound[c] = rotl(i_hv[c], (c * ROT_STEP) % D);
        end
    end

    always_comb begin
        for (int i = 0; i < D; i++) begin
            o_sum[i] = '0;
            for (int c = 0; c < CH; c++) begin
                o_sum[i] = o_sum[i] + SW'(w_bound[c][i]);
            end
        end
    end

endmodule

// File: rtl/hv_spatiotemporal_bundler.sv
// Accumulates bound/bundled samples over WIN samples and thresholds them into one query HV.
// Optional HV_BUNDLER_SKID_EN lets the next window accumulate while the last query waits.
module hv_spatiotemporal_bundler
    import hdc_pkg::*;
#(
    parameter int unsigned WIN      = 10,
    parameter int unsigned ROT_STEP = 7,
    parameter int unsigned THRESH   = 3
) (
    input  logic     clk,
    input  logic     nrst,
    input  logic     in_valid,
    input  chan_hv_t in_hv,
    output logic     in_ready,
    output logic     out_valid,
    output hv_t      out_hv,
    input  logic     out_ready,
    output logic     win_overflow
);

    localparam int unsigned MAXC = CH * WIN;
    localparam int unsigned CW   = $clog2(MAXC + 1);
    localparam int unsigned SCW  = (WIN > 1) ? $clog2(WIN) : 1;

    bund_state_e              r_state, w_state_d;
    logic                     r_live;
    logic [SCW-1:0]           r_scnt;
    logic [D-1:0][CW-1:0]     r_acc;
    logic [D-1:0][SW-1:0]     r_slast;
    hv_t                      r_out_hv;
    logic                     r_out_valid;

    logic [D-1:0][SW-1:0]     w_sum;
    logic [D-1:0][CW-1:0]     w_tot;
    hv_t                      w_query;
    logic                     w_accept;
    logic                     w_last;
    logic                     w_load;

    hv_spatial_bind #(
        .ROT_STEP (ROT_STEP)
    ) u_bind (
        .i_hv  (in_hv),
        .o_sum (w_sum)
    );

    assign w_accept     = in_valid & in_ready;
    assign w_last       = (r_scnt == SCW'(WIN - 1));
    assign out_valid    = r_out_valid;
    assign out_hv       = r_out_hv;
    assign win_overflow = 1'b0;

    // The final sample is held in r_slast rather than added, so THRESH sees acc + s_last.
    always_comb begin
        for (int i = 0; i < D; i++) begin
            w_tot[i]   = r_acc[i] + CW'(r_slast[i]);
            w_query[i] = (w_tot[i] >= CW'(THRESH));
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_load    = 1'b0;
        in_ready  = 1'b0;
        unique case (r_state)
            StAccum: begin
                in_ready = r_live;
                if (w_accept && w_last) begin
                    w_state_d = StThresh;
                end
            end
            StThresh: begin
`ifdef HV_BUNDLER_SKID_EN
                if (!r_out_valid || out_ready) begin
                    w_load    = 1'b1;
                    w_state_d = StAccum;
                end
`else
                w_load    = 1'b1;
                w_state_d = StEmit;
`endif
            end
            StEmit: begin
                if (out_ready) begin
                    w_state_d = StAccum;
                end
            end
            default: w_state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state     <= StAccum;
            r_live      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_hv    <= '0;
        end else begin
            r_state <= w_state_d;
            r_live  <= 1'b1;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_hv    <= w_query;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_scnt  <= '0;
            r_acc   <= '0;
            r_slast <= '0;
        end else begin
            if (w_accept) begin
                r_scnt <= w_last ? '0 : r_scnt + 1'b1;
            end
            if (w_accept && w_last) begin
                r_slast <= w_sum;
            end
            if (w_load) begin
                r_acc <= '0;
            end else if (w_accept && !w_last) begin
                for (int i = 0; i < D; i++) begin
                    r_acc[i] <= r_acc[i] + CW'(w_sum[i]);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (nrst) begin
            for (int i = 0; i < D; i++) begin
                assert (w_tot[i] <= CW'(MAXC))
                    else $error("bundler count overrun at bit %0d: %0d", i, w_tot[i]);
            end
        end
    end

endmodule

// File: tb/tb_hv_spatiotemporal_bundler.sv
// Self-checking bench for hv_spatiotemporal_bundler with a queue-based expected-query scoreboard.
module tb_hv_spatiotemporal_bundler;

    localparam int D   = 64;
    localparam int CH  = 4;
    localparam int WIN = 10;
    localparam int ROT = 7;
    localparam int TH  = 3;

    logic                  clk = 1'b0;
    logic                  nrst = 1'b0;
    logic                  in_valid = 1'b0;
    logic [CH-1:0][D-1:0]  in_hv = '0;
    logic                  in_ready;
    logic                  out_valid;
    logic [D-1:0]          out_hv;
    logic                  out_ready = 1'b0;
    logic                  win_overflow;

    int            n_vec = 0;
    int            n_err = 0;
    int            cnt[D];
    int            nsamp = 0;
    logic [D-1:0]  exp_q[$];

    always #5 clk = ~clk;

    hv_spatiotemporal_bundler #(
        .WIN      (WIN),
        .ROT_STEP (ROT),
        .THRESH   (TH)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .in_valid     (in_valid),
        .in_hv        (in_hv),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_hv       (out_hv),
        .out_ready    (out_ready),
        .win_overflow (win_overflow)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < D; i++) cnt[i] = 0;
        nsamp = 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [CH-1:0][D-1:0] x);
        logic [D-1:0] e;
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < D; i++)
                if (x[c][i]) cnt[(i + c * ROT) % D]++;
        nsamp++;
        if (nsamp == WIN) begin
            for (int i = 0; i < D; i++) begin
                e[i] = (cnt[i] >= TH);
                cnt[i] = 0;
            end
            exp_q.push_back(e);
            nsamp = 0;
        end
    endtask

    function automatic logic [CH-1:0][D-1:0] rand_hv();
        logic [CH-1:0][D-1:0] x;
        for (int c = 0; c < CH; c++) x[c] = {$urandom, $urandom};
        return x;
    endfunction

    function automatic logic [CH-1:0][D-1:0] fill_hv(input logic [D-1:0] v);
        logic [CH-1:0][D-1:0] x;
        for (int c = 0; c < CH; c++) x[c] = v;
        return x;
    endfunction

    // Present one sample and hold it until accepted; returns just after the accept edge.
    task automatic send(input logic [CH-1:0][D-1:0] x);
        bit got;
        got = 0;
        in_valid = 1'b1;
        in_hv = x;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) got = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_hv = '0;
        n_vec++;
        if (got) model_accept(x);
        else begin
            n_err++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
    endtask

    // Wait for a query, compare it to the scoreboard head, then complete the handshake.
    task automatic collect(input string name, output logic [D-1:0] obs);
        logic [D-1:0] e;
        int k;
        k = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        obs = out_hv;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: out_valid=%b hv=%h but no query expected", name, out_valid, out_hv);
        end else begin
            e = exp_q.pop_front();
            if (out_valid !== 1'b1 || out_hv !== e) begin
                n_err++;
                $display("FAIL %s: out_valid=%b hv=%h required valid=1 hv=%h",
                         name, out_valid, out_hv, e);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [D-1:0] obs;
        bit bad;
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec += 4;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_in_ready: got %b required 0", in_ready);
        end
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_out_valid: got %b required 0", out_valid);
        end
        if (out_hv !== '0) begin
            n_err++; $display("FAIL rst_out_hv: got %h required 0", out_hv);
        end
        if (win_overflow !== 1'b0) begin
            n_err++; $display("FAIL rst_overflow: got %b required 0", win_overflow);
        end
        @(posedge clk);
        #1;
        nrst = 1'b1;
        model_reset();
        for (int s = 0; s < 5; s++) send(fill_hv('1));
        nrst = 1'b0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        model_reset();
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_pulse_in_ready: got %b required 0", in_ready);
        end
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad = 1;
        end
        n_vec++;
        if (bad) begin
            n_err++; $display("FAIL rst_no_output: out_valid seen 1 required 0");
        end
        @(posedge clk);
        #1;
        for (int s = 0; s < WIN; s++) send(rand_hv());
        collect("rst_next_window", obs);
    endtask

    task automatic test_single_bit();
        logic [D-1:0] obs;
        logic [D-1:0] want;
        want = 64'h0000_0000_0020_4081;
        for (int s = 0; s < WIN; s++) send(fill_hv(64'h1));
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL single_lat_early: out_valid=%b required 0", out_valid);
        end
        @(negedge clk);
        n_vec += 2;
        if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL single_lat: out_valid=%b required 1", out_valid);
        end
        if (out_hv !== want) begin
            n_err++; $display("FAIL single_hv: got %h required %h", out_hv, want);
        end
        collect("single_bit", obs);
    endtask

    task automatic test_threshold();
        logic [D-1:0] obs;
        for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < WIN; s++) begin
                logic [CH-1:0][D-1:0] x;
                x = '0;
                if (s < 2 + w) x[0] = 64'h20;
                send(x);
            end
            collect("thresh_window", obs);
            n_vec++;
            if (obs[5] !== (w == 1)) begin
                n_err++;
                $display("FAIL thresh_bit5_w%0d: got %b required %b", w, obs[5], (w == 1));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [D-1:0] obs;
        logic [D-1:0] held;
        bit bad_hv;
        bit bad_rdy;
        int k;
        for (int s = 0; s < WIN; s++) send(rand_hv());
        k = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        held = out_hv;
        bad_hv = 0;
        bad_rdy = 0;
`ifdef HV_BUNDLER_SKID_EN
        @(posedge clk);
        #1;
        for (int s = 0; s < WIN; s++) send(rand_hv());
        for (int c = 0; c < 20 - WIN; c++) begin
            @(negedge clk);
            if (out_hv !== held || out_valid !== 1'b1) bad_hv = 1;
            if (in_ready !== 1'b0) bad_rdy = 1;
        end
`else
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_hv !== held || out_valid !== 1'b1) bad_hv = 1;
            if (in_ready !== 1'b0) bad_rdy = 1;
        end
`endif
        n_vec += 2;
        if (bad_hv) begin
            n_err++; $display("FAIL bp_stable: hv=%h valid=%b required hv=%h valid=1",
                              out_hv, out_valid, held);
        end
        if (bad_rdy) begin
            n_err++; $display("FAIL bp_in_ready: got %b required 0", in_ready);
        end
        @(posedge clk);
        #1;
        collect("bp_first", obs);
`ifdef HV_BUNDLER_SKID_EN
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_second_lat: out_valid=%b required 1", out_valid);
        end
        @(posedge clk);
        #1;
        collect("bp_second", obs);
`endif
    endtask

    task automatic test_bubbles();
        logic [D-1:0] obs;
        for (int s = 0; s < WIN; s++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            if (s == WIN - 1) begin
                @(negedge clk);
                n_vec++;
                if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL bubbles_count: in_ready=%b out_valid=%b required 1/0 after %0d",
                             in_ready, out_valid, s);
                end
                @(posedge clk);
                #1;
            end
            send(fill_hv('1));
        end
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL bubbles_thresh_ready: got %b required 0", in_ready);
        end
        collect("bubbles", obs);
    endtask

    task automatic test_dense();
        logic [D-1:0] obs;
        for (int s = 0; s < WIN; s++) send(fill_hv('1));
        collect("dense", obs);
    endtask

    task automatic test_random();
        logic [D-1:0] obs;
        for (int w = 0; w < 3; w++) begin
            for (int s = 0; s < WIN; s++) send(rand_hv());
            collect("random", obs);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_bit();
        test_threshold();
        test_backpressure();
        test_bubbles();
        test_dense();
        test_random();
        n_vec++;
        if (win_overflow !== 1'b0) begin
            n_err++; $display("FAIL overflow_flag: got %b required 0", win_overflow);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
